// File: rtl/dda_step_driver.sv
// Two-axis STEP/DIR pulse generator fed by DDA interpolator step requests.
// Each axis buffers requests in a signed pending counter and paces them out with DIR setup, HIGH and LOW timing.
module dda_step_driver #(
  parameter int PULSE_W   = 4,
  parameter int LOW_W     = 4,
  parameter int DIR_SETUP = 2,
  parameter int PEND_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] xe,
  input  logic [31:0] ye,
  input  logic        Ax,
  input  logic        fAx,
  input  logic        Ay,
  input  logic        fAy,
  input  logic        start_in,
  output logic        step_x,
  output logic        dir_x,
  output logic        step_y,
  output logic        dir_y,
  output logic [31:0] pos_x,
  output logic [31:0] pos_y,
  output logic        busy,
  output logic        done,
  output logic        at_end,
  output logic        err_ovf,
  output logic        err_conflict
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam int CNT_MAX0 = (PULSE_W > LOW_W) ? PULSE_W : LOW_W;
  localparam int CNT_MAX  = (CNT_MAX0 > DIR_SETUP) ? CNT_MAX0 : DIR_SETUP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIGH_LD   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LOW_LD    = CNT_W'(LOW_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(DIR_SETUP - 1);

  localparam logic signed [PEND_W:0]   ONE_E   = (PEND_W+1)'(1);
  localparam logic signed [PEND_W:0]   ZERO_E  = {(PEND_W+1){1'b0}};
  localparam logic signed [PEND_W:0]   LIM_HI  = (PEND_W+1)'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [PEND_W:0]   LIM_LO  = -LIM_HI;
  localparam logic signed [PEND_W-1:0] PEND_Z  = {PEND_W{1'b0}};

  state_t                   st_q   [2];
  logic [CNT_W-1:0]         cnt_q  [2];
  logic signed [PEND_W-1:0] pend_q [2];
  logic signed [PEND_W-1:0] pend_d [2];
  logic                     step_q [2];
  logic                     dir_q  [2];
  logic [31:0]              pos_q  [2];
  logic [31:0]              tgt_q  [2];

  logic                     req_p_s    [2];
  logic                     req_n_s    [2];
  logic                     issue_s    [2];
  logic                     turn_s     [2];
  logic                     ovf_s      [2];
  logic                     conflict_s [2];
  logic signed [PEND_W:0]   issd_s     [2];
  logic signed [PEND_W:0]   reqd_s     [2];
  logic signed [PEND_W:0]   base_s     [2];
  logic signed [PEND_W:0]   net_s      [2];

  logic start_q, seen_q, done_q, err_ovf_q, err_conflict_q;
  logic busy_s, done_set_s;

  // Per-axis issue decision and net pending update (request plus issue, overflow checked on the sum)
  always_comb begin
    req_p_s[0] = Ax;
    req_p_s[1] = Ay;
    req_n_s[0] = fAx;
    req_n_s[1] = fAy;
    for (int a = 0; a < 2; a++) begin
      issue_s[a]    = 1'b0;
      turn_s[a]     = 1'b0;
      ovf_s[a]      = 1'b0;
      conflict_s[a] = 1'b0;
      issd_s[a]     = ZERO_E;
      reqd_s[a]     = ZERO_E;
      if (pend_q[a] != PEND_Z) begin
        if (dir_q[a] == ~pend_q[a][PEND_W-1]) begin
          issue_s[a] = (st_q[a] == IDLE) || ((st_q[a] == SETUP) && (cnt_q[a] == CNT_ZERO));
        end else begin
          turn_s[a] = (st_q[a] == IDLE);
        end
      end else begin
        issue_s[a] = 1'b0;
      end
      if (issue_s[a]) begin
        issd_s[a] = pend_q[a][PEND_W-1] ? ONE_E : -ONE_E;
      end else begin
        issd_s[a] = ZERO_E;
      end
      if (en) begin
        if (req_p_s[a] && req_n_s[a]) begin
          conflict_s[a] = 1'b1;
        end else if (req_p_s[a]) begin
          reqd_s[a] = ONE_E;
        end else if (req_n_s[a]) begin
          reqd_s[a] = -ONE_E;
        end else begin
          reqd_s[a] = ZERO_E;
        end
      end else begin
        reqd_s[a] = ZERO_E;
      end
      base_s[a] = {pend_q[a][PEND_W-1], pend_q[a]} + issd_s[a];
      net_s[a]  = base_s[a] + reqd_s[a];
      if ((net_s[a] > LIM_HI) || (net_s[a] < LIM_LO)) begin
        ovf_s[a]  = 1'b1;
        pend_d[a] = base_s[a][PEND_W-1:0];
      end else begin
        pend_d[a] = net_s[a][PEND_W-1:0];
      end
    end
  end

  // Motion-complete detection
  always_comb begin
    busy_s = (pend_q[0] != PEND_Z) || (pend_q[1] != PEND_Z) ||
             (st_q[0] != IDLE) || (st_q[1] != IDLE);
    done_set_s = (seen_q || start_q) && !start_in && !busy_s;
  end

  // Axis FSMs, position tracking and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q        <= 1'b0;
      seen_q         <= 1'b0;
      done_q         <= 1'b0;
      err_ovf_q      <= 1'b0;
      err_conflict_q <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= IDLE;
        cnt_q[a]  <= CNT_ZERO;
        pend_q[a] <= PEND_Z;
        step_q[a] <= 1'b0;
        dir_q[a]  <= 1'b0;
        pos_q[a]  <= 32'd0;
        tgt_q[a]  <= 32'd0;
      end
    end else if (load) begin
      start_q        <= start_in;
      seen_q         <= 1'b0;
      done_q         <= 1'b0;
      err_ovf_q      <= 1'b0;
      err_conflict_q <= 1'b0;
      pos_q[0]       <= x0;
      pos_q[1]       <= y0;
      tgt_q[0]       <= xe;
      tgt_q[1]       <= ye;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= IDLE;
        cnt_q[a]  <= CNT_ZERO;
        pend_q[a] <= PEND_Z;
        step_q[a] <= 1'b0;
      end
    end else begin
      start_q        <= start_in;
      seen_q         <= seen_q | start_q;
      done_q         <= done_q | done_set_s;
      err_ovf_q      <= err_ovf_q | ovf_s[0] | ovf_s[1];
      err_conflict_q <= err_conflict_q | conflict_s[0] | conflict_s[1];
      for (int a = 0; a < 2; a++) begin
        pend_q[a] <= pend_d[a];
        case (st_q[a])
          IDLE: begin
            if (issue_s[a]) begin
              st_q[a]   <= HIGH;
              cnt_q[a]  <= HIGH_LD;
              step_q[a] <= 1'b1;
              pos_q[a]  <= dir_q[a] ? pos_q[a] + 32'd1 : pos_q[a] - 32'd1;
            end else if (turn_s[a]) begin
              st_q[a]  <= SETUP;
              cnt_q[a] <= SETUP_LD;
              dir_q[a] <= ~pend_q[a][PEND_W-1];
            end else begin
              st_q[a] <= IDLE;
            end
          end
          SETUP: begin
            if (cnt_q[a] != CNT_ZERO) begin
              cnt_q[a] <= cnt_q[a] - CNT_ONE;
            end else if (issue_s[a]) begin
              st_q[a]   <= HIGH;
              cnt_q[a]  <= HIGH_LD;
              step_q[a] <= 1'b1;
              pos_q[a]  <= dir_q[a] ? pos_q[a] + 32'd1 : pos_q[a] - 32'd1;
            end else begin
              // queued step was cancelled during setup; re-evaluate from IDLE
              st_q[a] <= IDLE;
            end
          end
          HIGH: begin
            if (cnt_q[a] != CNT_ZERO) begin
              cnt_q[a] <= cnt_q[a] - CNT_ONE;
            end else begin
              st_q[a]   <= LOW;
              cnt_q[a]  <= LOW_LD;
              step_q[a] <= 1'b0;
            end
          end
          LOW: begin
            if (cnt_q[a] != CNT_ZERO) begin
              cnt_q[a] <= cnt_q[a] - CNT_ONE;
            end else begin
              st_q[a] <= IDLE;
            end
          end
          default: begin
            st_q[a]   <= IDLE;
            step_q[a] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_x       = step_q[0];
  assign dir_x        = dir_q[0];
  assign step_y       = step_q[1];
  assign dir_y        = dir_q[1];
  assign pos_x        = pos_q[0];
  assign pos_y        = pos_q[1];
  assign busy         = busy_s;
  assign done         = done_q;
  assign at_end       = (pos_q[0] == tgt_q[0]) && (pos_q[1] == tgt_q[1]);
  assign err_ovf      = err_ovf_q;
  assign err_conflict = err_conflict_q;

endmodule
